// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-serial arithmetic units.
// State encoding is common to the adder and subtractor sequencers.
package bit_serial_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_fs.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
// Purely combinational; one instance is time-shared over all bit positions.
module bit_serial_fs (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_x;

  assign w_x    = i_a ^ i_b;
  assign o_d    = w_x ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~w_x & i_bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: diff = A - B over WIDTH clocks.
// Load/start/done protocol matches the bit-serial adder.
module bit_serial_subtractor
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_sa;
  logic             r_sb;
  logic             w_d;
  logic             w_bout;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  bit_serial_fs u_fs (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bin (r_bin),
    .o_d   (w_d),
    .o_bout(w_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_next = SUB;
      SUB:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_part <= '0;
      r_cnt  <= '0;
      r_bin  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            r_a    <= A;
            r_b    <= B;
            r_sa   <= A[WIDTH-1];
            r_sb   <= B[WIDTH-1];
            r_part <= '0;
          end
          // A fresh start must never inherit a stale borrow or count
          if (load || start) begin
            r_bin <= 1'b0;
            r_cnt <= '0;
          end
        end
        SUB: begin
          r_part <= {w_d, r_part[WIDTH-1:1]};
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_bin  <= w_bout;
          r_cnt  <= r_cnt + CW'(1);
        end
        DONE: begin
          diff   <= r_part;
          borrow <= r_bin;
          ovf    <= (r_sa != r_sb) && (r_part[WIDTH-1] != r_sa);
          done   <= 1'b1;
          r_bin  <= 1'b0;
          r_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor with a result scoreboard.
// Expected results are modelled at start time and popped on done.
module tb_bit_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         busy;
  logic         done;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .start (start),
    .A     (A),
    .B     (B),
    .diff  (diff),
    .borrow(borrow),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    e.d  = a - b;
    e.br = (a < b);
    e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Wait for done with a bounded budget, then score the result.
  task automatic wait_done(input string tag, input bit poke);
    int   lat;
    exp_t e;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      load  = 1'b0;
      if (poke && k == 2) begin
        load  = 1'b1;
        start = 1'b1;
        A     = '0;
        B     = '0;
      end
      if (done) lat = k;
      else if (k == 3) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_lat"}, 32'(lat), 32'd6);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      if (lat != 0) begin
        chk({tag, "_diff"}, 32'(diff), 32'(e.d));
        chk({tag, "_borrow"}, 32'(borrow), 32'(e.br));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit same,
                        input bit poke);
    if (!same) begin
      load = 1'b1;
      A    = a;
      B    = b;
      @(negedge clk);
      load = 1'b0;
    end
    load  = same;
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    wait_done(tag, poke);
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("op9m3", 4'd9, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    chk("op9m3_pulse", 32'(done), 32'd0);
    chk("op9m3_hold", 32'(diff), 32'd6);

    run_op("op3m9", 4'd3, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    run_op("op8m1", 4'd8, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    run_op("op5m5", 4'd5, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    run_op("opFm1_same", 4'hF, 4'h1, 1'b1, 1'b1);
    @(negedge clk);
    chk("opFm1_hold", 32'(diff), 32'hE);

    // Abort: reset two clocks after start
    load = 1'b1;
    A    = 4'd9;
    B    = 4'd3;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Back-to-back: second start on the done cycle
    run_op("b2b_first", 4'd9, 4'd3, 1'b0, 1'b0);
    load  = 1'b1;
    start = 1'b1;
    A     = 4'd2;
    B     = 4'd7;
    sb.push_back(model(4'd2, 4'd7));
    wait_done("b2b_second", 1'b0);
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
